// File: rtl/shake_pkg.sv
// Shared SHAKE parameters and the output-dump state encoding.
package shake_pkg;

    localparam int W                   = 64;
    localparam int SHAKE128_RATE_WORDS = 21;
    localparam int SHAKE256_RATE_WORDS = 17;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_e;

endpackage

// File: rtl/shake_word_shifter.sv
// Loadable rate-block shift register: word 0 is exposed, shift moves the next word down by W.
// Load has priority over shift; contents hold when neither is asserted.
module shake_word_shifter #(
    parameter int W     = shake_pkg::W,
    parameter int WORDS = shake_pkg::SHAKE128_RATE_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift_en,
    input  logic [WORDS*W-1:0] load_dat,
    output logic [W-1:0]       word0
);

    logic [WORDS*W-1:0] shreg_q;
    logic [WORDS*W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_dat;
        end else if (shift_en) begin
            shreg_d = {{W{1'b0}}, shreg_q[WORDS*W-1:W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign word0 = shreg_q[W-1:0];

endmodule

// File: rtl/shake_dump_stage.sv
// Output-buffer consumer: captures one rate block, streams its words valid/ready, holds dout on stall.
// SHAKE_DUMP_EARLY_RELEASE_EN: advertise availability during the final accept for zero-bubble reload.
module shake_dump_stage #(
    parameter int W          = shake_pkg::W,
    parameter int RATE_WORDS = shake_pkg::SHAKE128_RATE_WORDS,
    parameter int CNT_W      = $clog2(RATE_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    output_buffer_we,
    input  logic [RATE_WORDS*W-1:0] block_in,
    input  logic [CNT_W-1:0]        block_words,
    input  logic                    last_output_block_wr,
    output logic                    output_buffer_available,
    output logic [W-1:0]            dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    digest_done
);

    import shake_pkg::*;

    dump_state_e      state_q, state_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic             last_flag_q, last_flag_d;
    logic             digest_done_q, digest_done_d;
    logic [CNT_W-1:0] eff_words;
    logic             streaming;
    logic             last_word;
    logic             accept;
    logic             load;

    assign streaming = (state_q == STREAM);
    assign last_word = (words_left_q == CNT_W'(1));
    assign accept    = streaming && dout_ready;

`ifdef SHAKE_DUMP_EARLY_RELEASE_EN
    assign output_buffer_available = !streaming || (dout_ready && last_word);
`else
    assign output_buffer_available = !streaming;
`endif

    assign load = output_buffer_we && output_buffer_available;

    // Zero or oversized counts mean a full rate block.
    always_comb begin
        eff_words = block_words;
        if (block_words == '0 || block_words > CNT_W'(RATE_WORDS)) begin
            eff_words = CNT_W'(RATE_WORDS);
        end
    end

    always_comb begin
        state_d       = state_q;
        words_left_d  = words_left_q;
        last_flag_d   = last_flag_q;
        digest_done_d = accept && last_flag_q && last_word;
        if (load) begin
            state_d      = STREAM;
            words_left_d = eff_words;
            last_flag_d  = last_output_block_wr;
        end else if (accept) begin
            words_left_d = words_left_q - CNT_W'(1);
            if (last_word) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            words_left_q  <= '0;
            last_flag_q   <= 1'b0;
            digest_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_left_q  <= words_left_d;
            last_flag_q   <= last_flag_d;
            digest_done_q <= digest_done_d;
        end
    end

    shake_word_shifter #(
        .W     (W),
        .WORDS (RATE_WORDS)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (accept),
        .load_dat (block_in),
        .word0    (dout)
    );

    assign dout_valid  = streaming;
    assign dout_last   = streaming && last_flag_q && last_word;
    assign digest_done = digest_done_q;

endmodule
